// File: rtl/ram_arbiter_pkg.sv
// Shared types and default sizing for the two-port RAM arbiter.
// Optional build macro: RAM_ARBITER_FIXED_PRIO_EN (requester 0 always wins).
package ram_arbiter_pkg;

    localparam int ADDR_W_DEF    = 4;
    localparam int DATA_W_DEF    = 8;
    localparam int BURST_LEN_DEF = 4;

    // Wide enough for the largest legal BURST_LEN (15).
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        OWN0,
        OWN1
    } state_t;

endpackage : ram_arbiter_pkg

// File: rtl/ram_arbiter_ram_core.sv
// Single-port synchronous RAM: one write or one read per enabled cycle,
// read data registered and held until the next read.
module ram_core #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // NOTE: no reset on the array or its read register so the store maps onto
    // a plain RAM macro; contents survive rst by design.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule : ram_core

// File: rtl/ram_arbiter.sv
// Two-requester arbiter in front of a single-port RAM: round-robin with burst
// limit, or fixed priority to requester 0 when RAM_ARBITER_FIXED_PRIO_EN is set.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int BURST_LEN = BURST_LEN_DEF
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req_valid_0,
    output logic              req_ready_0,
    input  logic              req_we_0,
    input  logic [ADDR_W-1:0] req_addr_0,
    input  logic [DATA_W-1:0] req_wdata_0,
    output logic              resp_valid_0,
    output logic [DATA_W-1:0] resp_rdata_0,

    input  logic              req_valid_1,
    output logic              req_ready_1,
    input  logic              req_we_1,
    input  logic [ADDR_W-1:0] req_addr_1,
    input  logic [DATA_W-1:0] req_wdata_1,
    output logic              resp_valid_1,
    output logic [DATA_W-1:0] resp_rdata_1
);

    localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(BURST_LEN);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   count, count_nxt;
    logic               last_owner;
    logic               grant_0, grant_1;

    logic               mem_en, mem_we;
    logic [ADDR_W-1:0]  mem_addr;
    logic [DATA_W-1:0]  mem_wdata, mem_rdata;
    logic [DATA_W-1:0]  held_rdata_0, held_rdata_1;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        grant_0   = 1'b0;
        grant_1   = 1'b0;
        state_nxt = state;
        count_nxt = count;
`ifdef RAM_ARBITER_FIXED_PRIO_EN
        if (req_valid_0) begin
            grant_0   = 1'b1;
            state_nxt = OWN0;
            count_nxt = (state == OWN0 && count < BURST_MAX) ? count + 1'b1 : CNT_ONE;
        end else if (req_valid_1) begin
            grant_1   = 1'b1;
            state_nxt = OWN1;
            count_nxt = (state == OWN1 && count < BURST_MAX) ? count + 1'b1 : CNT_ONE;
        end else begin
            state_nxt = IDLE;
            count_nxt = '0;
        end
`else
        unique case (state)
            IDLE: begin
                // On a tie the requester that did not win last goes first.
                if (req_valid_0 && (!req_valid_1 || last_owner)) begin
                    grant_0   = 1'b1;
                    state_nxt = OWN0;
                    count_nxt = CNT_ONE;
                end else if (req_valid_1) begin
                    grant_1   = 1'b1;
                    state_nxt = OWN1;
                    count_nxt = CNT_ONE;
                end
            end
            OWN0: begin
                if (req_valid_0 && count < BURST_MAX) begin
                    grant_0   = 1'b1;
                    count_nxt = count + 1'b1;
                end else if (req_valid_1) begin
                    grant_1   = 1'b1;
                    state_nxt = OWN1;
                    count_nxt = CNT_ONE;
                end else if (req_valid_0) begin
                    grant_0   = 1'b1;
                    count_nxt = CNT_ONE;
                end else begin
                    state_nxt = IDLE;
                    count_nxt = '0;
                end
            end
            OWN1: begin
                if (req_valid_1 && count < BURST_MAX) begin
                    grant_1   = 1'b1;
                    count_nxt = count + 1'b1;
                end else if (req_valid_0) begin
                    grant_0   = 1'b1;
                    state_nxt = OWN0;
                    count_nxt = CNT_ONE;
                end else if (req_valid_1) begin
                    grant_1   = 1'b1;
                    count_nxt = CNT_ONE;
                end else begin
                    state_nxt = IDLE;
                    count_nxt = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                count_nxt = '0;
            end
        endcase
`endif
    end

    assign req_ready_0 = grant_0 & ~rst;
    assign req_ready_1 = grant_1 & ~rst;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            count      <= '0;
            last_owner <= 1'b1;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            if (grant_0) begin
                last_owner <= 1'b0;
            end else if (grant_1) begin
                last_owner <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Storage access and responses
    // ------------------------------------------------------------------
    assign mem_en    = req_ready_0 | req_ready_1;
    assign mem_we    = req_ready_1 ? req_we_1    : req_we_0;
    assign mem_addr  = req_ready_1 ? req_addr_1  : req_addr_0;
    assign mem_wdata = req_ready_1 ? req_wdata_1 : req_wdata_0;

    ram_core #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram_core (
        .clk   (clk),
        .en    (mem_en),
        .we    (mem_we),
        .addr  (mem_addr),
        .wdata (mem_wdata),
        .rdata (mem_rdata)
    );

    // The RAM read register is shared, so each requester keeps its own copy
    // of its last response to hold resp_rdata between pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_valid_0 <= 1'b0;
            resp_valid_1 <= 1'b0;
            held_rdata_0 <= '0;
            held_rdata_1 <= '0;
        end else begin
            resp_valid_0 <= req_ready_0 & ~req_we_0;
            resp_valid_1 <= req_ready_1 & ~req_we_1;
            if (resp_valid_0) begin
                held_rdata_0 <= mem_rdata;
            end
            if (resp_valid_1) begin
                held_rdata_1 <= mem_rdata;
            end
        end
    end

    assign resp_rdata_0 = resp_valid_0 ? mem_rdata : held_rdata_0;
    assign resp_rdata_1 = resp_valid_1 ? mem_rdata : held_rdata_1;

endmodule : ram_arbiter

// File: tb/tb_ram_arbiter.sv
// Directed self-checking bench for ram_arbiter (default parameters).
// Honours RAM_ARBITER_FIXED_PRIO_EN for the arbitration-policy sequence.
module tb_ram_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid_0, req_valid_1;
    logic       req_ready_0, req_ready_1;
    logic       req_we_0, req_we_1;
    logic [3:0] req_addr_0, req_addr_1;
    logic [7:0] req_wdata_0, req_wdata_1;
    logic       resp_valid_0, resp_valid_1;
    logic [7:0] resp_rdata_0, resp_rdata_1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ram_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid_0  (req_valid_0),
        .req_ready_0  (req_ready_0),
        .req_we_0     (req_we_0),
        .req_addr_0   (req_addr_0),
        .req_wdata_0  (req_wdata_0),
        .resp_valid_0 (resp_valid_0),
        .resp_rdata_0 (resp_rdata_0),
        .req_valid_1  (req_valid_1),
        .req_ready_1  (req_ready_1),
        .req_we_1     (req_we_1),
        .req_addr_1   (req_addr_1),
        .req_wdata_1  (req_wdata_1),
        .resp_valid_1 (resp_valid_1),
        .resp_rdata_1 (resp_rdata_1)
    );

    typedef struct {
        logic       v0, v1, we0, we1;
        logic [3:0] a0, a1;
        logic [7:0] d0, d1;
        logic       r0, r1, rv0, rv1;
        logic [7:0] rd0, rd1;
    } vec_t;

    vec_t vecs [15];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v0, input logic we0, input logic [3:0] a0, input logic [7:0] d0,
                         input logic v1, input logic we1, input logic [3:0] a1, input logic [7:0] d1);
        req_valid_0 = v0; req_we_0 = we0; req_addr_0 = a0; req_wdata_0 = d0;
        req_valid_1 = v1; req_we_1 = we1; req_addr_1 = a1; req_wdata_1 = d1;
    endtask

    initial begin
        //             v0 v1 we0 we1 a0     a1     d0     d1       r0 r1 rv0 rv1 rd0    rd1
        vecs[0]  = '{1, 0, 1, 0, 4'd3, 4'd0, 8'hA5, 8'h00,  1, 0, 0, 0, 8'h00, 8'h00};
        vecs[1]  = '{0, 1, 0, 0, 4'd0, 4'd3, 8'h00, 8'h00,  0, 1, 0, 0, 8'h00, 8'h00};
        vecs[2]  = '{0, 0, 0, 0, 4'd0, 4'd0, 8'h00, 8'h00,  0, 0, 0, 1, 8'h00, 8'hA5};
        vecs[3]  = '{1, 1, 1, 1, 4'd5, 4'd6, 8'h3C, 8'hC3,  1, 0, 0, 0, 8'h00, 8'hA5};
        vecs[4]  = '{1, 1, 0, 1, 4'd5, 4'd6, 8'h00, 8'hC3,  1, 0, 0, 0, 8'h00, 8'hA5};
        vecs[5]  = '{0, 1, 0, 1, 4'd0, 4'd6, 8'h00, 8'hC3,  0, 1, 1, 0, 8'h3C, 8'hA5};
        vecs[6]  = '{1, 0, 0, 0, 4'd6, 4'd0, 8'h00, 8'h00,  1, 0, 0, 0, 8'h3C, 8'hA5};
        vecs[7]  = '{0, 1, 0, 0, 4'd0, 4'd3, 8'h00, 8'h00,  0, 1, 1, 0, 8'hC3, 8'hA5};
        vecs[8]  = '{0, 0, 0, 0, 4'd0, 4'd0, 8'h00, 8'h00,  0, 0, 0, 1, 8'hC3, 8'hA5};
        vecs[9]  = '{1, 1, 0, 0, 4'd5, 4'd6, 8'h00, 8'h00,  1, 0, 0, 0, 8'hC3, 8'hA5};
        vecs[10] = '{0, 1, 0, 0, 4'd0, 4'd6, 8'h00, 8'h00,  0, 1, 1, 0, 8'h3C, 8'hA5};
        vecs[11] = '{0, 0, 0, 0, 4'd0, 4'd0, 8'h00, 8'h00,  0, 0, 0, 1, 8'h3C, 8'hC3};
        vecs[12] = '{0, 1, 0, 1, 4'd0, 4'd3, 8'h00, 8'h5A,  0, 1, 0, 0, 8'h3C, 8'hC3};
        vecs[13] = '{0, 1, 0, 0, 4'd0, 4'd3, 8'h00, 8'h00,  0, 1, 0, 0, 8'h3C, 8'hC3};
        vecs[14] = '{0, 0, 0, 0, 4'd0, 4'd0, 8'h00, 8'h00,  0, 0, 0, 1, 8'h3C, 8'h5A};

        rst = 1'b1;
        drive(0, 0, 4'd0, 8'h00, 0, 0, 4'd0, 8'h00);
        #3;
        check("reset ready_0", 8'(req_ready_0), 8'h00);
        check("reset ready_1", 8'(req_ready_1), 8'h00);
        check("reset resp_valid_0", 8'(resp_valid_0), 8'h00);
        check("reset resp_valid_1", 8'(resp_valid_1), 8'h00);
        check("reset resp_rdata_0", resp_rdata_0, 8'h00);
        check("reset resp_rdata_1", resp_rdata_1, 8'h00);
        @(negedge clk);
        rst = 1'b0;

        // Write/read traffic, priority hand-over, write-then-read forwarding.
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            drive(vecs[i].v0, vecs[i].we0, vecs[i].a0, vecs[i].d0,
                  vecs[i].v1, vecs[i].we1, vecs[i].a1, vecs[i].d1);
            #1;
            check($sformatf("vec%0d ready_0", i), 8'(req_ready_0), 8'(vecs[i].r0));
            check($sformatf("vec%0d ready_1", i), 8'(req_ready_1), 8'(vecs[i].r1));
            check($sformatf("vec%0d resp_valid_0", i), 8'(resp_valid_0), 8'(vecs[i].rv0));
            check($sformatf("vec%0d resp_valid_1", i), 8'(resp_valid_1), 8'(vecs[i].rv1));
            check($sformatf("vec%0d resp_rdata_0", i), resp_rdata_0, vecs[i].rd0);
            check($sformatf("vec%0d resp_rdata_1", i), resp_rdata_1, vecs[i].rd1);
        end

        // Reset right after a read is accepted: the response is lost.
        @(negedge clk);
        drive(0, 0, 4'd0, 8'h00, 1, 0, 4'd3, 8'h00);
        #1;
        check("pre-reset read ready_1", 8'(req_ready_1), 8'h01);
        @(posedge clk);
        #1;
        rst = 1'b1;
        drive(1, 0, 4'd3, 8'h00, 1, 0, 4'd3, 8'h00);
        #1;
        check("rst resp_valid_1", 8'(resp_valid_1), 8'h00);
        check("rst resp_rdata_1", resp_rdata_1, 8'h00);
        check("rst resp_rdata_0", resp_rdata_0, 8'h00);
        check("rst ready_0 gated", 8'(req_ready_0), 8'h00);
        check("rst ready_1 gated", 8'(req_ready_1), 8'h00);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post-reset tie ready_0", 8'(req_ready_0), 8'h01);
        check("post-reset tie ready_1", 8'(req_ready_1), 8'h00);
        check("post-reset resp_valid_1", 8'(resp_valid_1), 8'h00);
        @(negedge clk);
        drive(0, 0, 4'd0, 8'h00, 1, 0, 4'd3, 8'h00);
        #1;
        check("post-reset handover ready_1", 8'(req_ready_1), 8'h01);
        check("memory kept resp_valid_0", 8'(resp_valid_0), 8'h01);
        check("memory kept resp_rdata_0", resp_rdata_0, 8'h5A);
        @(negedge clk);
        drive(0, 0, 4'd0, 8'h00, 0, 0, 4'd0, 8'h00);
        #1;
        check("memory kept resp_valid_1", 8'(resp_valid_1), 8'h01);
        check("memory kept resp_rdata_1", resp_rdata_1, 8'h5A);

        // Both requesters valid continuously from reset.
        @(negedge clk);
        rst = 1'b1;
        drive(1, 0, 4'd3, 8'h00, 1, 0, 4'd3, 8'h00);
        @(negedge clk);
        rst = 1'b0;
`ifdef RAM_ARBITER_FIXED_PRIO_EN
        for (int i = 0; i < 10; i++) begin
            #1;
            check($sformatf("fixed cycle%0d ready_0", i), 8'(req_ready_0), 8'h01);
            check($sformatf("fixed cycle%0d ready_1", i), 8'(req_ready_1), 8'h00);
            @(negedge clk);
        end
        req_valid_0 = 1'b0;
        #1;
        check("fixed release ready_1", 8'(req_ready_1), 8'h01);
        check("fixed release ready_0", 8'(req_ready_0), 8'h00);
`else
        for (int i = 0; i < 12; i++) begin
            logic exp0;
            exp0 = ((i / 4) % 2) == 0;
            #1;
            check($sformatf("burst cycle%0d ready_0", i), 8'(req_ready_0), 8'(exp0));
            check($sformatf("burst cycle%0d ready_1", i), 8'(req_ready_1), 8'(!exp0));
            @(negedge clk);
        end
`endif
        drive(0, 0, 4'd0, 8'h00, 0, 0, 4'd0, 8'h00);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_ram_arbiter

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 The block SHALL have exactly one clock and one reset; reset is asynchronous and active-high.
REQ-002 Parameter ADDR_W, default 4, SHALL set the address width (2**ADDR_W words).
REQ-003 Parameter DATA_W, default 8, SHALL set the data word width.
REQ-004 Parameter BURST_LEN, default 4, range 1..15, SHALL set the maximum consecutive grants to one owner while the other requester waits.
REQ-005 clk  in  1  rising-edge clock for all state and storage.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 req_valid_0 / req_valid_1  in  1  requester n has a transaction pending.
REQ-008 req_ready_0 / req_ready_1  out  1  transaction n is accepted at this rising edge.
REQ-009 req_we_0 / req_we_1  in  1  1 = write, 0 = read.
REQ-010 req_addr_0 / req_addr_1  in  ADDR_W  word address.
REQ-011 req_wdata_0 / req_wdata_1  in  DATA_W  write data.
REQ-012 resp_valid_0 / resp_valid_1  out  1  one-cycle pulse: read data for requester n is valid.
REQ-013 resp_rdata_0 / resp_rdata_1  out  DATA_W  read data; holds its value between responses.

Function
REQ-014 The block SHALL own one single-port synchronous store of 2**ADDR_W x DATA_W; at most one access (read or write) per cycle.
REQ-015 A transaction SHALL be accepted at an edge where valid_n and ready_n are both 1; at most one ready SHALL be 1 per cycle.
REQ-016 ready_n SHALL be combinational from the current state and req_valid_*; it SHALL never be 1 while valid_n is 0.
REQ-017 Requester signals SHALL stay stable while valid_n=1 and ready_n=0; a requester SHALL NOT withdraw valid before acceptance.
REQ-018 An accepted write SHALL update memory at the accepting edge; no response is generated.
REQ-019 For an accepted read, resp_valid_n SHALL be 1 for exactly the next cycle, with resp_rdata_n = memory[addr] (latency 1).
REQ-020 A read accepted in the cycle after a write to the same address SHALL return the newly written data.
REQ-021 FSM states: IDLE, OWN0, OWN1. A burst counter (0..BURST_LEN) and a last_owner bit are held.
REQ-022 IDLE: if only one valid, grant it. If both valid, grant the requester that is not last_owner. Go to OWN(winner) with count=1. If none valid, stay.
REQ-023 OWNx with valid_x and count<BURST_LEN: grant x and increment count.
REQ-024 OWNx with valid_x and count==BURST_LEN: if the other requester is valid, grant it, go to OWN(other) and set count=1. Otherwise grant x and set count=1.
REQ-025 OWNx with valid_x=0: if the other requester is valid, grant it in the same cycle and go to OWN(other) with count=1. Otherwise go to IDLE with no grant.
REQ-026 last_owner SHALL update to the granted requester on every grant.
REQ-027 No idle bubble SHALL occur while any requester is valid; throughput is one transaction per cycle.

Reset
REQ-028 On rst: state=IDLE, count=0, last_owner=1, req_ready_*=0 while rst is high, resp_valid_*=0, resp_rdata_*=0.
REQ-029 A read accepted at the edge before reset assertion SHALL produce no response; memory contents are not reset.

Configuration
REQ-030 Macro RAM_ARBITER_FIXED_PRIO_EN defined: requester 0 SHALL win every cycle it is valid, preempting OWN1 immediately. BURST_LEN and last_owner SHALL NOT affect the grant.
REQ-031 Macro RAM_ARBITER_FIXED_PRIO_EN undefined: behaviour per REQ-022..REQ-026 (round-robin with burst).

Structure
REQ-032 Package ram_arbiter_pkg SHALL hold the FSM state enum and the default ADDR_W, DATA_W and BURST_LEN constants.
REQ-033 Storage SHALL be sub-module ram_core (single-port, synchronous write-or-read, registered read data); arbitration/FSM logic stays in ram_arbiter.

Verification
REQ-034 After reset, req0 writes addr 3 = 0xA5, then req1 reads addr 3 -> resp_valid_1 is high one cycle after acceptance, with resp_rdata_1=0xA5.
REQ-035 Both valid continuously from reset, BURST_LEN=4 -> grant sequence 0,0,0,0,1,1,1,1,0,... with one grant per cycle.
REQ-036 req0 owns with count=2 and drops valid while req1 is valid -> req1 is granted in the same cycle; no bubble.
REQ-037 rst asserted the cycle after a read is accepted -> no resp_valid pulse, resp_rdata=0, and the next tie grants req0.
REQ-038 With RAM_ARBITER_FIXED_PRIO_EN, both valid for 10 cycles -> req0 granted all 10 cycles; req1 is granted in the first cycle after req0 drops valid.
